// File: rtl/simd_cmd_seq_if.sv
// simd_cmd_seq_if: command stream (valid/ready) plus the init/load/fetch/ack
// handshake towards the device under test. The master side is the sequencer.
interface simd_cmd_seq_if #(
    parameter int unsigned IO_W = 16,
    parameter int unsigned TO_W = 16
);
    localparam int unsigned CMD_W = 4 + 1 + TO_W + IO_W;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_data;
    logic             dut_rst_n;
    logic             dut_init;
    logic             dut_load;
    logic             dut_fetch;
    logic [IO_W-1:0]  dut_idata;
    logic             dut_ack;
    logic [IO_W-1:0]  dut_odata;

    modport master (
        input  cmd_valid, cmd_data, dut_ack, dut_odata,
        output cmd_ready, dut_rst_n, dut_init, dut_load, dut_fetch, dut_idata
    );

    modport slave (
        output cmd_valid, cmd_data, dut_ack, dut_odata,
        input  cmd_ready, dut_rst_n, dut_init, dut_load, dut_fetch, dut_idata
    );
endinterface

// File: rtl/simd_cmd_seq.sv
// simd_cmd_seq: executes single-beat commands {op, hold, arg, data} against a
// DUT over the init/load/fetch/ack handshake, checks fetched data and reports
// pass/fail plus a cycle count.
// Build option: SIMD_SEQ_CONT_ON_ERR_EN -- timeout/mismatch set the sticky flag
// and execution continues; without it the first such error halts the sequencer.
module simd_cmd_seq #(
    parameter int unsigned IO_W  = 16,
    parameter int unsigned TO_W  = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simd_cmd_seq_if.master       bus,
    output logic                 done,
    output logic                 pass,
    output logic                 err_timeout,
    output logic                 err_mismatch,
    output logic                 err_opcode,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [IO_W-1:0]      last_exp,
    output logic [IO_W-1:0]      last_act
);
    localparam int unsigned CMD_W = 4 + 1 + TO_W + IO_W;

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpReset = 4'h1;
    localparam logic [3:0] OpClock = 4'h2;
    localparam logic [3:0] OpInit  = 4'h3;
    localparam logic [3:0] OpWait  = 4'h5;
    localparam logic [3:0] OpLoad  = 4'h6;
    localparam logic [3:0] OpFetch = 4'h7;
    localparam logic [3:0] OpEnd   = 4'hF;

    localparam logic [TO_W-1:0]  TO_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {StIdle, StRst, StWait, StInit, StLoad, StFetch, StHalt} state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   arg_q, arg_d;
    logic [IO_W-1:0]   data_q, data_d;
    logic              hold_q, hold_d;
    logic [IO_W-1:0]   idata_q, idata_d;
    logic              load_hold_q, load_hold_d;
    logic              fetch_hold_q, fetch_hold_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_mismatch_q, err_mismatch_d;
    logic              err_opcode_q, err_opcode_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [IO_W-1:0]   last_exp_q, last_exp_d;
    logic [IO_W-1:0]   last_act_q, last_act_d;

    logic [CMD_W-1:0]  cmd_word;
    logic [3:0]        cmd_op;
    logic              cmd_hold;
    logic [TO_W-1:0]   cmd_arg;
    logic [IO_W-1:0]   cmd_dat;
    logic              cmd_ready_w;
    logic              accept;
    logic [TO_W-1:0]   rst_last;
    logic              ev_timeout, ev_mismatch, xfer_ok;

    assign cmd_word = bus.cmd_data;
    assign cmd_op   = cmd_word[CMD_W-1 -: 4];
    assign cmd_hold = cmd_word[TO_W+IO_W];
    assign cmd_arg  = cmd_word[IO_W +: TO_W];
    assign cmd_dat  = cmd_word[IO_W-1:0];

    // run_q keeps cmd_ready and dut_rst_n low until the first clock after reset
    assign cmd_ready_w = run_q && (state_q == StIdle);
    assign accept      = bus.cmd_valid && cmd_ready_w;
    // RESET with arg=0 still holds the DUT in reset for one cycle
    assign rst_last    = (arg_q == '0) ? '0 : arg_q - TO_ONE;

    // Next-state, command execution and status update
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        arg_d          = arg_q;
        data_d         = data_q;
        hold_d         = hold_q;
        idata_d        = idata_q;
        load_hold_d    = load_hold_q;
        fetch_hold_d   = fetch_hold_q;
        done_d         = done_q;
        pass_d         = pass_q;
        err_timeout_d  = err_timeout_q;
        err_mismatch_d = err_mismatch_q;
        err_opcode_d   = err_opcode_q;
        err_count_d    = err_count_q;
        last_exp_d     = last_exp_q;
        last_act_d     = last_act_q;
        ev_timeout     = 1'b0;
        ev_mismatch    = 1'b0;
        xfer_ok        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // a held strobe lasts only until the next accepted command
                    load_hold_d  = 1'b0;
                    fetch_hold_d = 1'b0;
                    arg_d        = cmd_arg;
                    data_d       = cmd_dat;
                    hold_d       = cmd_hold;
                    cnt_d        = '0;
                    case (cmd_op)
                        OpNop, OpClock: ;
                        OpReset: state_d = StRst;
                        OpInit:  state_d = StInit;
                        OpWait:  if (cmd_arg != '0) state_d = StWait;
                        OpLoad: begin
                            state_d = StLoad;
                            idata_d = cmd_dat;
                        end
                        OpFetch: state_d = StFetch;
                        OpEnd: begin
                            state_d = StHalt;
                            done_d  = 1'b1;
                            pass_d  = !(err_timeout_q || err_mismatch_q || err_opcode_q);
                        end
                        default: begin
                            state_d      = StHalt;
                            done_d       = 1'b1;
                            pass_d       = 1'b0;
                            err_opcode_d = 1'b1;
                        end
                    endcase
                end
            end
            StRst: begin
                if (cnt_q == rst_last) state_d = StIdle;
                else                   cnt_d   = cnt_q + TO_ONE;
            end
            StWait: begin
                if (cnt_q == arg_q - TO_ONE) state_d = StIdle;
                else                         cnt_d   = cnt_q + TO_ONE;
            end
            StInit: state_d = StIdle;
            StLoad, StFetch: begin
                if (bus.dut_ack) begin
                    if (state_q == StFetch && bus.dut_odata != data_q) ev_mismatch = 1'b1;
                    else                                              xfer_ok     = 1'b1;
                end else if (arg_q != '0 && cnt_q == arg_q - TO_ONE) begin
                    ev_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_ONE;
                end
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase

        if (xfer_ok) begin
            state_d      = StIdle;
            load_hold_d  = hold_q && (state_q == StLoad);
            fetch_hold_d = hold_q && (state_q == StFetch);
        end

        if (ev_timeout || ev_mismatch) begin
            if (ev_timeout) err_timeout_d = 1'b1;
            if (ev_mismatch) begin
                err_mismatch_d = 1'b1;
                last_exp_d     = data_q;
                last_act_d     = bus.dut_odata;
            end
            if (err_count_q != '1) err_count_d = err_count_q + CNT_ONE;
`ifdef SIMD_SEQ_CONT_ON_ERR_EN
            state_d = StIdle;
`else
            state_d = StHalt;
            done_d  = 1'b1;
            pass_d  = 1'b0;
`endif
        end

        cycle_count_d = (done_q || cycle_count_q == '1) ? cycle_count_q
                                                        : cycle_count_q + CNT_ONE;
    end

    // State and status registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            run_q          <= 1'b0;
            cnt_q          <= '0;
            arg_q          <= '0;
            data_q         <= '0;
            hold_q         <= 1'b0;
            idata_q        <= '0;
            load_hold_q    <= 1'b0;
            fetch_hold_q   <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_mismatch_q <= 1'b0;
            err_opcode_q   <= 1'b0;
            err_count_q    <= '0;
            cycle_count_q  <= '0;
            last_exp_q     <= '0;
            last_act_q     <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= 1'b1;
            cnt_q          <= cnt_d;
            arg_q          <= arg_d;
            data_q         <= data_d;
            hold_q         <= hold_d;
            idata_q        <= idata_d;
            load_hold_q    <= load_hold_d;
            fetch_hold_q   <= fetch_hold_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_timeout_q  <= err_timeout_d;
            err_mismatch_q <= err_mismatch_d;
            err_opcode_q   <= err_opcode_d;
            err_count_q    <= err_count_d;
            cycle_count_q  <= cycle_count_d;
            last_exp_q     <= last_exp_d;
            last_act_q     <= last_act_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_w;
    assign bus.dut_rst_n = run_q && (state_q != StRst);
    assign bus.dut_init  = (state_q == StInit);
    assign bus.dut_load  = (state_q == StLoad) || load_hold_q;
    assign bus.dut_fetch = (state_q == StFetch) || fetch_hold_q;
    assign bus.dut_idata = idata_q;

    assign done         = done_q;
    assign pass         = pass_q;
    assign err_timeout  = err_timeout_q;
    assign err_mismatch = err_mismatch_q;
    assign err_opcode   = err_opcode_q;
    assign err_count    = err_count_q;
    assign cycle_count  = cycle_count_q;
    assign last_exp     = last_exp_q;
    assign last_act     = last_act_q;
endmodule
